// File: rtl/avalon_stream_bridge.sv
// rtl/avalon_stream_bridge.sv - Avalon-MM responder bridging HPS register accesses to h2f/f2h valid/ready streams
// Optional irq output and CTRL irq_en bit enabled by AVALON_STREAM_BRIDGE_IRQ_EN.

module avalon_stream_bridge_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [DATA_W-1:0]         din,
    input  logic                      pop,
    output logic [DATA_W-1:0]         dout,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;
    logic              do_push;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO is taken only when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset)
            mem[wr_ptr] <= din;
    end
endmodule

module avalon_stream_bridge #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [1:0]        address,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] h2f_data,
    output logic              h2f_valid,
    input  logic              h2f_ready,
    input  logic [DATA_W-1:0] f2h_data,
    input  logic              f2h_valid,
    output logic              f2h_ready
`ifdef AVALON_STREAM_BRIDGE_IRQ_EN
    ,
    output logic              irq
`endif
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ADDR_TX     = 2'd0;
    localparam logic [1:0] ADDR_RX     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    logic              wr_en;
    logic              rd_en;
    logic              tx_push;
    logic              rx_pop;
    logic              flush;
    logic              stat_wr;
    logic              ovf;
    logic              unf;
    logic              ovf_set;
    logic              unf_set;
    logic [AW:0]       h2f_count;
    logic [AW:0]       f2h_count;
    logic              h2f_full;
    logic              h2f_empty;
    logic              f2h_full;
    logic              f2h_empty;
    logic [DATA_W-1:0] f2h_head;
    logic [DATA_W-1:0] status;

    // A write wins over a simultaneous read; readdata then holds.
    assign wr_en   = chipselect & write;
    assign rd_en   = chipselect & read & ~write;
    assign tx_push = wr_en && (address == ADDR_TX);
    assign stat_wr = wr_en && (address == ADDR_STATUS);
    assign flush   = wr_en && (address == ADDR_CTRL) && writedata[0];
    assign rx_pop  = rd_en && (address == ADDR_RX);

    assign ovf_set = tx_push & h2f_full & ~(h2f_valid & h2f_ready);
    assign unf_set = rx_pop & f2h_empty;

    assign h2f_valid = ~h2f_empty;
    assign f2h_ready = ~f2h_full;

    avalon_stream_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_h2f_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (tx_push),
        .din   (writedata),
        .pop   (h2f_ready),
        .dout  (h2f_data),
        .count (h2f_count),
        .full  (h2f_full),
        .empty (h2f_empty)
    );

    avalon_stream_bridge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_f2h_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (f2h_valid & f2h_ready),
        .din   (f2h_data),
        .pop   (rx_pop),
        .dout  (f2h_head),
        .count (f2h_count),
        .full  (f2h_full),
        .empty (f2h_empty)
    );

    always_comb begin
        status        = '0;
        status[0]     = h2f_full;
        status[1]     = h2f_empty;
        status[2]     = f2h_full;
        status[3]     = f2h_empty;
        status[4]     = ovf;
        status[5]     = unf;
        status[15:8]  = 8'(h2f_count);
        status[23:16] = 8'(f2h_count);
    end

    // Same-cycle set beats a write-1-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= (ovf & ~(stat_wr & writedata[4])) | ovf_set;
            unf <= (unf & ~(stat_wr & writedata[5])) | unf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (rd_en) begin
            case (address)
                ADDR_RX:     readdata <= f2h_empty ? '0 : f2h_head;
                ADDR_STATUS: readdata <= status;
                default:     readdata <= '0;
            endcase
        end
    end

`ifdef AVALON_STREAM_BRIDGE_IRQ_EN
    logic irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr_en && (address == ADDR_CTRL))
                irq_en <= writedata[1];
            irq <= irq_en & (~f2h_empty | ovf | unf);
        end
    end
`endif
endmodule

// File: tb/tb_avalon_stream_bridge.sv
// tb/tb_avalon_stream_bridge.sv - scoreboard bench for avalon_stream_bridge (irq checks under AVALON_STREAM_BRIDGE_IRQ_EN)

module tb_avalon_stream_bridge;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              chipselect;
    logic              read;
    logic              write;
    logic [1:0]        address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic [DATA_W-1:0] h2f_data;
    logic              h2f_valid;
    logic              h2f_ready;
    logic [DATA_W-1:0] f2h_data;
    logic              f2h_valid;
    logic              f2h_ready;
`ifdef AVALON_STREAM_BRIDGE_IRQ_EN
    logic              irq;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] h2f_q[$];
    logic [31:0] f2h_q[$];

    always #5 clk = ~clk;

    avalon_stream_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .h2f_data   (h2f_data),
        .h2f_valid  (h2f_valid),
        .h2f_ready  (h2f_ready),
        .f2h_data   (f2h_data),
        .f2h_valid  (f2h_valid),
        .f2h_ready  (f2h_ready)
`ifdef AVALON_STREAM_BRIDGE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        step();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] rd_q[$];
        rd_q.push_back(exp);
        chipselect = 1'b1; read = 1'b1; address = a;
        step();
        chipselect = 1'b0; read = 1'b0;
        check(tag, readdata, rd_q.pop_front());
    endtask

    task automatic h2f_front(input string tag);
        if (h2f_q.size() == 0)
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else
            check(tag, h2f_data, h2f_q.pop_front());
    endtask

    task automatic rx_expect(input string tag);
        if (f2h_q.size() == 0)
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        else
            bus_rd(tag, 2'd1, f2h_q.pop_front());
    endtask

    task automatic drain_h2f(input string tag, input int n);
        h2f_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            check({tag, "_valid"}, 32'(h2f_valid), 32'd1);
            h2f_front({tag, "_data"});
            step();
        end
        h2f_ready = 1'b0;
        check({tag, "_done"}, 32'(h2f_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0; h2f_ready = 1'b0;
        f2h_data = '0; f2h_valid = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_readdata", readdata, 32'h0);
        check("rst_h2f_valid", 32'(h2f_valid), 32'd0);
        check("rst_f2h_ready", 32'(f2h_ready), 32'd1);
        bus_rd("rst_status", 2'd2, 32'h0000_000A);

        // single word through h2f
        h2f_q.push_back(32'hDEADBEEF);
        bus_wr(2'd0, 32'hDEADBEEF);
        check("h2f_valid_1", 32'(h2f_valid), 32'd1);
        check("h2f_data_1", h2f_data, h2f_q[0]);
        bus_rd("status_cnt1", 2'd2, 32'h0000_0108);
        drain_h2f("h2f_single", 1);

        // overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i <= 16; i++) begin
            if (i < DEPTH) h2f_q.push_back(32'(i));
            bus_wr(2'd0, 32'(i));
        end
        bus_rd("status_ovf", 2'd2, 32'h0000_1019);
        drain_h2f("h2f_ovf", 16);
        bus_wr(2'd2, 32'h10);
        bus_rd("status_ovf_clr", 2'd2, 32'h0000_000A);

        // full h2f with fabric pop in the same cycle accepts the push
        for (int i = 0; i < DEPTH; i++) begin
            h2f_q.push_back(32'h100 + 32'(i));
            bus_wr(2'd0, 32'h100 + 32'(i));
        end
        h2f_ready = 1'b1;
        h2f_front("h2f_pushpop_head");
        h2f_q.push_back(32'hABC);
        bus_wr(2'd0, 32'hABC);
        h2f_ready = 1'b0;
        bus_rd("status_pushpop", 2'd2, 32'h0000_1009);
        drain_h2f("h2f_pushpop", 16);

        // f2h three words then underflow
        f2h_valid = 1'b1;
        foreach (f2h_q[i]) ;
        for (int i = 1; i <= 3; i++) begin
            f2h_data = 32'h11 * 32'(i);
            f2h_q.push_back(f2h_data);
            step();
        end
        f2h_valid = 1'b0;
        for (int i = 0; i < 3; i++) rx_expect("rx_word");
        bus_rd("rx_unf_data", 2'd1, 32'h0);
        bus_rd("status_unf", 2'd2, 32'h0000_002A);
        bus_wr(2'd2, 32'h20);
        bus_rd("status_unf_clr", 2'd2, 32'h0000_000A);

        // unmapped reads, ignored RX write, read+write collision
        bus_rd("rd_tx_zero", 2'd0, 32'h0);
        bus_wr(2'd1, 32'h1234);
        bus_rd("rd_ctrl_zero", 2'd3, 32'h0);
        bus_rd("status_after_rxwr", 2'd2, 32'h0000_000A);
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h0;
        step();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        check("rdwr_hold", readdata, 32'h0000_000A);

        // f2h full, fabric offers a word while HPS reads
        f2h_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            f2h_data = 32'h200 + 32'(i);
            f2h_q.push_back(f2h_data);
            step();
        end
        f2h_data = 32'h300;
        f2h_q.push_back(32'h300);
        check("f2h_full_ready", 32'(f2h_ready), 32'd0);
        rx_expect("rx_full_oldest");
        step();
        f2h_valid = 1'b0;
        bus_rd("status_f2h_full", 2'd2, 32'h0010_0006);
        for (int i = 0; i < DEPTH; i++) rx_expect("rx_full_drain");
        bus_rd("status_f2h_drained", 2'd2, 32'h0000_000A);

        // flush both FIFOs
        bus_wr(2'd0, 32'h55);
        f2h_valid = 1'b1; f2h_data = 32'h66;
        step();
        f2h_valid = 1'b0;
        bus_wr(2'd3, 32'h1);
        bus_rd("status_flush", 2'd2, 32'h0000_000A);

`ifdef AVALON_STREAM_BRIDGE_IRQ_EN
        bus_wr(2'd3, 32'h2);
        check("irq_idle", 32'(irq), 32'd0);
        f2h_valid = 1'b1; f2h_data = 32'h77;
        f2h_q.push_back(32'h77);
        step();
        f2h_valid = 1'b0;
        check("irq_lag", 32'(irq), 32'd0);
        step();
        check("irq_set", 32'(irq), 32'd1);
        rx_expect("irq_word");
        step();
        check("irq_clr", 32'(irq), 32'd0);
`endif

        // reset mid-stream discards everything
        bus_wr(2'd0, 32'h99);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_h2f_valid", 32'(h2f_valid), 32'd0);
        bus_rd("rst_mid_status", 2'd2, 32'h0000_000A);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
